// File: rtl/ja88_pkg.sv
// Shared ja88 execution-stage definitions.
// Divider FSM states, operand width select and the #DE vector.
package ja88_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX
  } div_state_t;

  typedef struct packed {
    logic [5:0] n;
    logic [4:0] sbit;
  } width_t;

  localparam logic [7:0] VEC_DE = 8'h00;

  function automatic width_t width_sel(
    input logic isize,
    input logic opsize
  );
    width_t w;
    unique case (1'b1)
      !isize:           w = '{n: 6'd8,  sbit: 5'd7};
      isize && !opsize: w = '{n: 6'd16, sbit: 5'd15};
      default:          w = '{n: 6'd32, sbit: 5'd31};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/alu_div.sv
// Radix-2 restoring divider for x86 DIV/IDIV.
// Byte/word/dword, signed and unsigned, with #DE detection.
module alu_div
  import ja88_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        isize,
  input  logic        opsize,
  input  logic        signed_op,
  input  logic [63:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        fault
);

  div_state_t  state;
  logic        isz_q;
  logic        osz_q;
  logic        sgn_q;
  logic [63:0] dvd_q;
  logic [31:0] dvs_q;
  logic        q_neg;
  logic        r_neg;
  logic        ovf;
  logic [31:0] d_mag;
  logic [32:0] r_q;
  logic [31:0] q_q;
  logic [4:0]  cnt;

  width_t      w;
  logic [31:0] mask;
  logic [63:0] dvd_sx;
  logic [31:0] dvs_sx;
  logic        dvd_neg;
  logic        dvs_neg;
  logic [63:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] hi;
  logic [31:0] lo_al;
  logic [32:0] t;
  logic [33:0] diff;
  logic [31:0] q_mag;
  logic [31:0] lim_pos;
  logic        fix_fault;
  logic [31:0] q_out;
  logic [31:0] r_out;

  // Operand magnitudes, trial subtract and sign fix-up.
  always_comb begin
    w      = width_sel(isz_q, osz_q);
    mask   = 32'hFFFF_FFFF >> (6'd32 - w.n);
    dvd_sx = dvd_q;
    dvs_sx = dvs_q;
    unique case (1'b1)
      !isz_q: begin
        dvd_sx = {{48{sgn_q & dvd_q[15]}}, dvd_q[15:0]};
        dvs_sx = {{24{sgn_q & dvs_q[7]}}, dvs_q[7:0]};
      end
      isz_q && !osz_q: begin
        dvd_sx = {{32{sgn_q & dvd_q[31]}}, dvd_q[31:0]};
        dvs_sx = {{16{sgn_q & dvs_q[15]}}, dvs_q[15:0]};
      end
      default: begin
        dvd_sx = dvd_q;
        dvs_sx = dvs_q;
      end
    endcase
    dvd_neg = sgn_q & dvd_sx[63];
    dvs_neg = sgn_q & dvs_q[w.sbit];
    dvd_mag = dvd_neg ? -dvd_sx : dvd_sx;
    dvs_mag = dvs_neg ? -dvs_sx : dvs_sx;
    hi      = 32'(dvd_mag >> w.n);
    lo_al   = dvd_mag[31:0] << (6'd32 - w.n);

    t    = {r_q[31:0], q_q[31]};
    diff = {1'b0, t} - {2'b00, d_mag};

    q_mag     = q_q & mask;
    lim_pos   = mask >> 1;
    fix_fault = sgn_q & (ovf |
                (q_neg ? (q_mag > lim_pos + 32'd1)
                       : (q_mag > lim_pos)));
    q_out = (q_neg ? -q_mag : q_mag) & mask;
    r_out = (r_neg ? -r_q[31:0] : r_q[31:0]) & mask;
  end

  // Sequencer with registered status and results.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      isz_q <= 1'b0;
      osz_q <= 1'b0;
      sgn_q <= 1'b0;
      dvd_q <= '0;
      dvs_q <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      ovf   <= 1'b0;
      d_mag <= '0;
      r_q   <= '0;
      q_q   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      fault <= 1'b0;
      quot  <= '0;
      rem   <= '0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            isz_q <= isize;
            osz_q <= opsize;
            sgn_q <= signed_op;
            dvd_q <= dividend;
            dvs_q <= divisor;
            busy  <= 1'b1;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          d_mag <= dvs_mag;
          q_neg <= dvd_neg ^ dvs_neg;
          r_neg <= dvd_neg;
          ovf   <= hi >= dvs_mag;
          if (dvs_mag == '0 || (!sgn_q && hi >= dvs_mag)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            fault <= 1'b1;
            state <= S_IDLE;
          end else begin
            r_q   <= {1'b0, hi};
            q_q   <= lo_al;
            cnt   <= 5'(w.n - 6'd1);
            state <= S_RUN;
          end
        end
        S_RUN: begin
          r_q <= diff[33] ? t : diff[32:0];
          q_q <= {q_q[30:0], ~diff[33]};
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 5'd1;
        end
        S_FIX: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          fault <= fix_fault;
          if (!fix_fault) begin
            quot <= q_out;
            rem  <= r_out;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div.sv
// Directed bench for alu_div.
// Hand-computed quotients, remainders, faults and cycle timing.
module tb_alu_div;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic        isize;
  logic        opsize;
  logic        signed_op;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        fault;

  int n_cmp = 0;
  int n_bad = 0;
  int dcyc;
  logic dflt;
  int busy_err;
  int flt_err;

  alu_div dut (
    .clock(clock),
    .resetn(resetn),
    .start(start),
    .isize(isize),
    .opsize(opsize),
    .signed_op(signed_op),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quot(quot),
    .rem(rem),
    .fault(fault)
  );

  always #5 clock = ~clock;

  task automatic run_op(
    input logic        isz,
    input logic        osz,
    input logic        sgn,
    input logic [63:0] dvd,
    input logic [31:0] dvs
  );
    isize     = isz;
    opsize    = osz;
    signed_op = sgn;
    dividend  = dvd;
    divisor   = dvs;
    start     = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    dcyc = -1;
    dflt = 1'b0;
    busy_err = 0;
    flt_err = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      if (done) begin
        dcyc = c;
        dflt = fault;
        if (busy) busy_err++;
        break;
      end
      if (!busy) busy_err++;
      if (fault) flt_err++;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    start = 1'b0;
    isize = 1'b0;
    opsize = 1'b0;
    signed_op = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({busy, done, fault} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 000", {busy, done, fault});
    end
    n_cmp++;
    if ({quot, rem} !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_out got %h/%h want 0/0", quot, rem);
    end
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_byte_div;
    run_op(1'b0, 1'b0, 1'b0, 64'h0064, 32'h07);
    n_cmp++;
    if (dcyc !== 11) begin
      n_bad++;
      $display("FAIL bdiv_cyc got %0d want 11", dcyc);
    end
    n_cmp++;
    if ({dflt, quot, rem} !== {1'b0, 32'h0E, 32'h02}) begin
      n_bad++;
      $display("FAIL bdiv_res got f%b %h/%h want f0 0e/02", dflt, quot, rem);
    end
    n_cmp++;
    if (busy_err !== 0 || flt_err !== 0) begin
      n_bad++;
      $display("FAIL bdiv_busy got %0d/%0d errs want 0/0", busy_err, flt_err);
    end
  endtask

  task automatic test_word_idiv;
    @(negedge clock);
    run_op(1'b1, 1'b0, 1'b1, 64'hFFFF_FF9C, 32'h0007);
    n_cmp++;
    if (dcyc !== 19) begin
      n_bad++;
      $display("FAIL widiv_cyc got %0d want 19", dcyc);
    end
    n_cmp++;
    if ({dflt, quot, rem} !== {1'b0, 32'h0000FFF2, 32'h0000FFFE}) begin
      n_bad++;
      $display("FAIL widiv_res got f%b %h/%h want f0 fff2/fffe", dflt, quot, rem);
    end
  endtask

  task automatic test_dword_div;
    @(negedge clock);
    run_op(1'b1, 1'b1, 1'b0, 64'h1_0000_0000, 32'h10);
    n_cmp++;
    if (dcyc !== 35) begin
      n_bad++;
      $display("FAIL ddiv_cyc got %0d want 35", dcyc);
    end
    n_cmp++;
    if ({dflt, quot, rem} !== {1'b0, 32'h10000000, 32'h0}) begin
      n_bad++;
      $display("FAIL ddiv_res got f%b %h/%h want f0 10000000/0", dflt, quot, rem);
    end
    @(negedge clock);
    run_op(1'b1, 1'b1, 1'b0, 64'h1234, 32'h0);
    n_cmp++;
    if (dcyc !== 2 || dflt !== 1'b1) begin
      n_bad++;
      $display("FAIL dzero got cyc %0d f%b want cyc 2 f1", dcyc, dflt);
    end
    n_cmp++;
    if ({quot, rem} !== {32'h10000000, 32'h0}) begin
      n_bad++;
      $display("FAIL dzero_keep got %h/%h want 10000000/0", quot, rem);
    end
  endtask

  task automatic test_byte_overflow;
    @(negedge clock);
    run_op(1'b0, 1'b0, 1'b0, 64'h0100, 32'h01);
    n_cmp++;
    if (dcyc !== 2 || dflt !== 1'b1) begin
      n_bad++;
      $display("FAIL bovf got cyc %0d f%b want cyc 2 f1", dcyc, dflt);
    end
    n_cmp++;
    if (quot !== 32'h10000000) begin
      n_bad++;
      $display("FAIL bovf_keep got %h want 10000000", quot);
    end
  endtask

  task automatic test_byte_idiv_bounds;
    @(negedge clock);
    run_op(1'b0, 1'b0, 1'b1, 64'hFF80, 32'h01);
    n_cmp++;
    if ({dcyc == 11, dflt, quot, rem} !== {1'b1, 1'b0, 32'h80, 32'h0}) begin
      n_bad++;
      $display("FAIL bidiv_min got cyc %0d f%b %h/%h want cyc 11 f0 80/0", dcyc, dflt, quot, rem);
    end
    @(negedge clock);
    run_op(1'b0, 1'b0, 1'b1, 64'h0080, 32'h01);
    n_cmp++;
    if (dcyc !== 11 || dflt !== 1'b1) begin
      n_bad++;
      $display("FAIL bidiv_pos got cyc %0d f%b want cyc 11 f1", dcyc, dflt);
    end
    n_cmp++;
    if (quot !== 32'h80) begin
      n_bad++;
      $display("FAIL bidiv_keep got %h want 80", quot);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clock);
    run_op(1'b0, 1'b0, 1'b0, 64'h0064, 32'h07);
    n_cmp++;
    if (dcyc !== 11) begin
      n_bad++;
      $display("FAIL b2b_first got cyc %0d want 11", dcyc);
    end
    run_op(1'b0, 1'b0, 1'b0, 64'h00C8, 32'h09);
    n_cmp++;
    if (dcyc !== 11) begin
      n_bad++;
      $display("FAIL b2b_cyc got %0d want 11", dcyc);
    end
    n_cmp++;
    if ({dflt, quot, rem} !== {1'b0, 32'h16, 32'h02}) begin
      n_bad++;
      $display("FAIL b2b_res got f%b %h/%h want f0 16/02", dflt, quot, rem);
    end
  endtask

  task automatic test_reset_abort;
    int seen;
    @(negedge clock);
    isize = 1'b1;
    opsize = 1'b1;
    signed_op = 1'b0;
    dividend = 64'h1_0000_0000;
    divisor = 32'h10;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (5) @(negedge clock);
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, fault, quot, rem} !== 67'h0) begin
      n_bad++;
      $display("FAIL abort_out got b%b d%b %h/%h want 0", busy, done, quot, rem);
    end
    seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (done) seen++;
    end
    resetn = 1'b1;
    repeat (2) begin
      @(negedge clock);
      if (done) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL abort_done got %0d pulses want 0", seen);
    end
    run_op(1'b0, 1'b0, 1'b0, 64'h0064, 32'h07);
    n_cmp++;
    if ({dcyc == 11, dflt, quot, rem} !== {1'b1, 1'b0, 32'h0E, 32'h02}) begin
      n_bad++;
      $display("FAIL abort_next got cyc %0d f%b %h/%h want cyc 11 f0 0e/02", dcyc, dflt, quot, rem);
    end
  endtask

  initial begin
    test_reset;
    test_byte_div;
    test_word_idiv;
    test_dword_div;
    test_byte_overflow;
    test_byte_idiv_bounds;
    test_back_to_back;
    test_reset_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
